// File: rtl/clock_div_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : clock_div_pkg                                          |
// | Description : Shared types, defaults and helpers for the clock-      |
// |               divide sequencer (state encoding, ratio width,         |
// |               half-period rounding).                                 |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package clock_div_pkg;

   // Default width of the divide ratio; legal ratios are 1..2^DIV_W-1.
   localparam int unsigned C_DIV_W = 8;

   // Controller states: idle, dividing, dividing with a ratio queued.
   typedef enum logic [1:0] {
      STOP = 2'd0,
      RUN  = 2'd1,
      PEND = 2'd2
   } state_t;

   // ceil(n/2): number of high cycles of the divided level for ratio n.
   // Evaluated at 32 bits so any ratio width below 32 cannot overflow.
   function automatic logic [31:0] half_up(input logic [31:0] n);
      return (n + 32'd1) >> 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/clock_div_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : clock_div_counter                                      |
// | Description : Period counter for the clock-divide sequencer. Counts  |
// |               0..cur_div-1 while enabled, flags the last cycle of    |
// |               each period and decodes clk_en / div_level.            |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module clock_div_counter
   import clock_div_pkg::*;
#(
   parameter int DIV_W = C_DIV_W
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             enable,
   input  logic [DIV_W-1:0] cur_div,
   output logic             wrap,
   output logic             clk_en,
   output logic             div_level
);

   logic [DIV_W-1:0] cnt_q;
   logic [DIV_W-1:0] cnt_d;
   logic             w_last;
   logic             w_first;
   logic             w_high;

   // Decode period position; cur_div is never zero so cur_div-1 cannot underflow
   always_comb begin
      w_last  = (cnt_q == (cur_div - DIV_W'(1)));
      w_first = (cnt_q == '0);
      w_high  = (32'(cnt_q) < half_up(32'(cur_div)));
      if (!enable) begin
         cnt_d = '0;
      end else if (w_last) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + DIV_W'(1);
      end
      wrap      = enable & w_last;
      clk_en    = enable & w_first;
      div_level = enable & w_high;
   end

   // Period counter; held at zero while stopped so a restart begins a fresh period
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/clock_div_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : clock_div_ctrl                                         |
// | Description : Runtime-programmable clock-enable divider. Emits a     |
// |               one-cycle enable every N cycles plus a divided level,  |
// |               and applies ratio changes only at period boundaries.   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module clock_div_ctrl
   import clock_div_pkg::*;
#(
   parameter int DIV_W       = C_DIV_W,
   parameter int DEFAULT_DIV = 3
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             run,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [DIV_W-1:0] req_div,
   output logic             req_err,
   output logic             clk_en,
   output logic             div_level,
   output logic [DIV_W-1:0] cur_div,
   output logic             active
);

   state_t           state_q;
   state_t           state_d;
   logic [DIV_W-1:0] cur_div_q;
   logic [DIV_W-1:0] cur_div_d;
   logic [DIV_W-1:0] pend_div_q;
   logic [DIV_W-1:0] pend_div_d;
   logic             req_err_q;
   logic             req_err_d;
   logic             req_ready_q;
   logic             req_ready_d;
   logic             active_q;
   logic             active_d;

   logic             w_enable;
   logic             w_wrap;
   logic             w_xfer;
   logic             w_zero;
   logic             w_take;

   assign w_enable = (state_q != STOP);

   clock_div_counter #(
      .DIV_W (DIV_W)
   ) u_counter (
      .clock     (clock),
      .reset_n   (reset_n),
      .enable    (w_enable),
      .cur_div   (cur_div_q),
      .wrap      (w_wrap),
      .clk_en    (clk_en),
      .div_level (div_level)
   );

   // Next-state, ratio update and handshake decisions
   always_comb begin
      state_d    = state_q;
      cur_div_d  = cur_div_q;
      pend_div_d = pend_div_q;
      w_xfer     = req_valid & req_ready_q;
      w_zero     = (req_div == '0);
      w_take     = w_xfer & ~w_zero;
      req_err_d  = w_xfer & w_zero;

      case (state_q)
         STOP: begin
            // No period in flight, so a new ratio can take effect at once
            if (w_take) begin
               cur_div_d = req_div;
            end
            if (run) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (w_wrap) begin
               if (w_take) begin
                  cur_div_d = req_div;
               end
               if (!run) begin
                  state_d = STOP;
               end
            end else if (w_take) begin
               pend_div_d = req_div;
               state_d    = PEND;
            end
         end
         PEND: begin
            if (w_wrap) begin
               cur_div_d  = pend_div_q;
               pend_div_d = '0;
               state_d    = run ? RUN : STOP;
            end
         end
         default: begin
            state_d = STOP;
         end
      endcase

      req_ready_d = (state_d != PEND);
      active_d    = (state_d != STOP);
   end

   // Controller state and registered status outputs
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= STOP;
         cur_div_q   <= DIV_W'(DEFAULT_DIV);
         pend_div_q  <= '0;
         req_err_q   <= 1'b0;
         req_ready_q <= 1'b1;
         active_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cur_div_q   <= cur_div_d;
         pend_div_q  <= pend_div_d;
         req_err_q   <= req_err_d;
         req_ready_q <= req_ready_d;
         active_q    <= active_d;
      end
   end

   assign req_ready = req_ready_q;
   assign req_err   = req_err_q;
   assign cur_div   = cur_div_q;
   assign active    = active_q;

endmodule
`default_nettype wire

// File: doc/clock_div_ctrl.md
Name: clock_div_ctrl

Overview:
- Synthesizable, runtime-programmable clock-divide sequencer that replaces the simulation-only fixed divide-by-3 black box.
- Emits a one-cycle clock-enable pulse every N input cycles, plus a phase-aligned divided-level indicator.
- Accepts ratio changes over a valid/ready handshake and applies them only at a period boundary, so no truncated or glitched period is ever produced.
- Sits between a config/CSR requester and downstream logic that runs on clock enables, never gated clocks.

Parameters:
- DIV_W, 8, width of divide ratio; legal ratios 1..2^DIV_W-1.
- DEFAULT_DIV, 3, ratio loaded at reset; must be nonzero.

Ports:
- clock  in  1  single clock for all state.
- reset_n  in  1  asynchronous active-low reset.
- run  in  1  level; 1 = generate enables, 0 = stop at next period boundary.
- req_valid  in  1  ratio-change request.
- req_ready  out  1  controller can accept a request.
- req_div  in  DIV_W  requested ratio N.
- req_err  out  1  one-cycle pulse: accepted request had N==0 and was discarded.
- clk_en  out  1  one-cycle pulse at the start of each divided period.
- div_level  out  1  divided clock level; high for ceil(N/2) cycles, low for floor(N/2).
- cur_div  out  DIV_W  ratio currently in effect.
- active  out  1  state is RUN or PEND.

Behaviour:
- Reset (async assert, sync-clean deassert):
  - state=STOP, cnt=0, cur_div=DEFAULT_DIV, pend_div=0.
  - clk_en=0, div_level=0, req_ready=1, req_err=0, active=0.
- All outputs derive from registers only; no input-to-output combinational path.
- Counter: cnt runs 0..cur_div-1. wrap = (cnt==cur_div-1). On wrap, cnt->0; otherwise cnt+1.
- In RUN/PEND:
  - clk_en = (cnt==0).
  - div_level = (cnt < ceil(cur_div/2)), computed as (cur_div+1)>>1 at DIV_W+1 bits.
- In STOP: clk_en=0, div_level=0, cnt held at 0.
- Ratio 1: clk_en=1 every cycle and div_level constantly 1.
- FSM:
  - STOP -> RUN when run=1. The first cycle in RUN has cnt=0, so clk_en=1. Latency is 1 cycle from run sampled high.
  - RUN, accepted request with N!=0 and not wrap: pend_div=N, go to PEND.
  - RUN, accepted request with N!=0 on the wrap cycle: cur_div=N at that boundary; stay in RUN.
  - PEND, on wrap: cur_div=pend_div, go to RUN. The new ratio governs the period beginning the next cycle.
  - RUN/PEND with run=0: the current period completes. On wrap, go to STOP.
    - A pending ratio is applied at that same wrap.
    - If run returns to 1 before the wrap, operation continues uninterrupted.
  - STOP, accepted request with N!=0: cur_div=N next cycle and state stays STOP. Immediate apply is safe because no period is in flight.
- Handshake:
  - req_ready = (state != PEND).
  - Transfer occurs on req_valid & req_ready.
  - req_valid held while not ready is allowed; req_div must stay stable while held.
  - An N==0 transfer: req_err=1 the next cycle; no state or ratio change.
- Simultaneous run rise and request while in STOP: the ratio updates and the state goes to RUN in the same cycle. The first period uses the new N.
- Reset mid-PEND discards pend_div; cur_div returns to DEFAULT_DIV.
- Width: cnt is DIV_W bits. A ratio of all-ones is legal and must not overflow.

Decomposition:
- Package clock_div_pkg:
  - state typedef {STOP, RUN, PEND}.
  - DIV_W default.
  - function half_up(N) returning ceil(N/2).
- Sub-module clock_div_counter: cnt register, wrap detect, clk_en and div_level generation; inputs enable and cur_div.
- The FSM, handshake and ratio registers stay in clock_div_ctrl.

Test Plan:
- Reset, then run=1 with DEFAULT_DIV=3 -> clk_en on cycles 1,4,7,...; div_level pattern 1,1,0 repeating; active=1.
- While running N=3, request N=5 mid-period (cnt=1) -> req_ready=0 until the wrap. The next period has 5 cycles with div_level 1,1,1,0,0, and cur_div=5 from that boundary.
- Request N=4 presented exactly on the wrap cycle -> accepted with req_ready=1; the very next period is 4 cycles; no PEND cycle occurs.
- Request N=0 -> req_err pulses one cycle; cur_div and clk_en spacing unchanged. Separately, N=1 -> clk_en=1 every cycle and div_level constant 1.
- run=0 at cnt=1 of an N=5 period -> enables stop after cnt=4. The next cycle shows STOP, clk_en=0, div_level=0. Restarting run=1 gives clk_en=1 after 1 cycle.
- Assert reset_n=0 asynchronously during PEND with pend_div=7 -> outputs clear immediately. After release, cur_div=3 and state=STOP.
